// File: rtl/playfield_renderer_if.sv
// Bus bundle between game-state logic / video timing and the playfield renderer.
// The master side drives pixel coordinates and board state; the slave side returns colour and handshake.
interface playfield_renderer_if #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 20
);
    logic [9:0]             DrawX;
    logic [9:0]             DrawY;
    logic                   frame_start;
    logic [COLS*ROWS-1:0]   map;
    logic [2*COLS*ROWS-1:0] map_color;
    logic [15:0]            piece;
    logic [4:0]             PieceX;
    logic [4:0]             PieceY;
    logic [1:0]             piece_color;
    logic [ROWS-1:0]        clear_rows;
    logic                   clear_req;
    logic                   busy;
    logic                   clear_done;
    logic [3:0]             Red;
    logic [3:0]             Green;
    logic [3:0]             Blue;

    modport master (
        output DrawX, DrawY, frame_start, map, map_color, piece, PieceX, PieceY,
               piece_color, clear_rows, clear_req,
        input  busy, clear_done, Red, Green, Blue
    );

    modport slave (
        input  DrawX, DrawY, frame_start, map, map_color, piece, PieceX, PieceY,
               piece_color, clear_rows, clear_req,
        output busy, clear_done, Red, Green, Blue
    );
endinterface

// File: rtl/playfield_renderer.sv
// Two-stage registered colour generator for the Tetris playfield, with a
// frame-synchronised row-clear flash animation and req/done handshake.
module playfield_renderer #(
    parameter int unsigned COLS         = 10,
    parameter int unsigned ROWS         = 20,
    parameter int unsigned CELL_LOG2    = 4,
    parameter int unsigned ORG_X        = 15,
    parameter int unsigned ORG_Y        = 5,
    parameter int unsigned BEVEL        = 2,
    parameter int unsigned FLASH_PERIOD = 4,
    parameter int unsigned FLASH_FRAMES = 24
) (
    input  logic                 Clk,
    input  logic                 Reset,
    playfield_renderer_if.slave  bus
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned CELL_W  = COORD_W - CELL_LOG2;
    localparam int unsigned CX_W    = CELL_W + 2;
    localparam int unsigned CELL_PX = 1 << CELL_LOG2;
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned IDX_W   = $clog2(COLS * ROWS);
    localparam int unsigned MAX_W   = (COL_W > ROW_W) ? COL_W : ROW_W;
    localparam int unsigned PW      = ((MAX_W > 5) ? MAX_W : 5) + 1;
    localparam int unsigned CNT_W   = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned PER_W   = $clog2(FLASH_PERIOD + 1);

    typedef enum logic [1:0] {SH_SHADOW, SH_HIGH, SH_BODY} shade_e;
    typedef enum logic {S_IDLE, S_FLASH} state_e;

    // Palette entry packed as {shadow, highlight, body}.
    function automatic logic [35:0] palette(input logic [1:0] idx);
        logic [35:0] trio;
        case (idx)
            2'd0:    trio = {12'hC60, 12'hFA0, 12'hF70};
            2'd1:    trio = {12'h060, 12'h0C0, 12'h090};
            2'd2:    trio = {12'h006, 12'h00C, 12'h009};
            default: trio = {12'h806, 12'hF0D, 12'hC0A};
        endcase
        return trio;
    endfunction

    function automatic logic [11:0] pick(input shade_e sh, input logic [35:0] trio);
        logic [11:0] c;
        case (sh)
            SH_SHADOW: c = trio[35:24];
            SH_HIGH:   c = trio[23:12];
            default:   c = trio[11:0];
        endcase
        return c;
    endfunction

    // Stage 1: cell coordinates, board membership and bevel shade.
    logic signed [CX_W-1:0] cx_d, cy_d;
    logic [CELL_LOG2-1:0]   px_d, py_d;
    logic                   in_board_d;
    shade_e                 shade_d;

    always_comb begin
        cx_d = $signed(CX_W'(bus.DrawX >> CELL_LOG2)) - $signed(CX_W'(ORG_X));
        cy_d = $signed(CX_W'(bus.DrawY >> CELL_LOG2)) - $signed(CX_W'(ORG_Y));
        px_d = bus.DrawX[CELL_LOG2-1:0];
        py_d = bus.DrawY[CELL_LOG2-1:0];
        in_board_d = (cx_d >= 0) && (cx_d < $signed(CX_W'(COLS))) &&
                     (cy_d >= 0) && (cy_d < $signed(CX_W'(ROWS)));
        shade_d = SH_BODY;
        if (px_d < CELL_LOG2'(BEVEL) || py_d >= CELL_LOG2'(CELL_PX - BEVEL))
            shade_d = SH_SHADOW;
        else if (py_d < CELL_LOG2'(BEVEL) || px_d >= CELL_LOG2'(CELL_PX - BEVEL))
            shade_d = SH_HIGH;
    end

    logic             v1_q;
    logic             in_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    shade_e           shade_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_q    <= 1'b0;
            in_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            shade_q <= SH_BODY;
        end else begin
            v1_q    <= 1'b1;
            in_q    <= in_board_d;
            col_q   <= COL_W'(cx_d);
            row_q   <= ROW_W'(cy_d);
            shade_q <= shade_d;
        end
    end

    // Clear-animation FSM state.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic              phase_q, phase_d;
    logic [ROWS-1:0]   rows_q, rows_d;
    logic              done_q, done_d;
    logic              busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        phase_d = phase_q;
        rows_d  = rows_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.clear_req) begin
                    if (|bus.clear_rows) begin
                        state_d = S_FLASH;
                        rows_d  = bus.clear_rows;
                        cnt_d   = '0;
                        per_d   = '0;
                        phase_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.frame_start) begin
                    if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        per_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (per_q == PER_W'(FLASH_PERIOD - 1)) begin
                            per_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            per_d = per_q + PER_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            phase_q <= 1'b0;
            rows_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            phase_q <= phase_d;
            rows_q  <= rows_d;
            done_q  <= done_d;
            busy_q  <= (state_d == S_FLASH);
        end
    end

    // Stage 2: priority colour selection against live board state.
    logic [IDX_W-1:0] idx_c;
    logic [PW-1:0]    dc_c, dr_c;
    logic             map_hit_c, piece_hit_c;
    logic [11:0]      rgb_d, rgb_q;

    always_comb begin
        idx_c       = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
        dc_c        = PW'(col_q) - PW'(bus.PieceX);
        dr_c        = PW'(row_q) - PW'(bus.PieceY);
        map_hit_c   = bus.map[idx_c];
        piece_hit_c = (dc_c < PW'(4)) && (dr_c < PW'(4)) && bus.piece[{dr_c[1:0], dc_c[1:0]}];
        rgb_d       = '0;
        if (v1_q) begin
            if (!in_q)
                rgb_d = pick(shade_q, {12'h444, 12'hCCC, 12'h888});
            else if (busy_q && rows_q[row_q] && phase_q)
                rgb_d = 12'hFFF;
            else if (map_hit_c)
                rgb_d = pick(shade_q, palette(bus.map_color[{idx_c, 1'b0} +: 2]));
            else if (piece_hit_c)
                rgb_d = pick(shade_q, palette(bus.piece_color));
            else
                rgb_d = 12'hFFF;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) rgb_q <= '0;
        else       rgb_q <= rgb_d;
    end

    assign bus.Red        = rgb_q[11:8];
    assign bus.Green      = rgb_q[7:4];
    assign bus.Blue       = rgb_q[3:0];
    assign bus.busy       = busy_q;
    assign bus.clear_done = done_q;

endmodule
